// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC vectoring sequencer.
// Defaults mirror the C model's iteration settings.
package cordic_pkg;

    localparam int CORDIC_ITERATIONS      = 16;
    localparam int CORDIC_ITERATION_WIDTH = 4;
    // Start-to-done cycles without the quadrant pre-rotation step.
    localparam int CORDIC_LATENCY         = CORDIC_ITERATIONS + 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PRE   = 3'd2,
        ST_ITER  = 3'd3,
        ST_LATCH = 3'd4,
        ST_DONE  = 3'd5
    } cordic_state_e;

    function automatic int cordic_latency(input int iterations, input bit pre_taken);
        return iterations + 3 + (pre_taken ? 1 : 0);
    endfunction

endpackage

// File: rtl/cordic_sequencer_if.sv
// Control bundle between the CORDIC sequencer and its requester/datapath.
// The slave modport is the sequencer's view; master is the requester's.
interface cordic_sequencer_if #(
    parameter int ITERATION_WIDTH = 4
);
    logic                       start;
    logic                       abort;
    logic                       x_neg;
    logic                       busy;
    logic                       load;
    logic                       pre_rot;
    logic                       iter_en;
    logic [ITERATION_WIDTH-1:0] iter_idx;
    logic                       out_latch;
    logic                       done;

    modport master (
        output start, abort, x_neg,
        input  busy, load, pre_rot, iter_en, iter_idx, out_latch, done
    );

    modport slave (
        input  start, abort, x_neg,
        output busy, load, pre_rot, iter_en, iter_idx, out_latch, done
    );
endinterface

// File: rtl/cordic_iter_counter.sv
// Micro-rotation counter: clear has priority, enable increments, terminal flag at ITERATIONS-1.
// Latency 1 cycle; reaching terminal count while enabled returns to 0 so the count never wraps.
module cordic_iter_counter #(
    parameter int WIDTH      = 4,
    parameter int ITERATIONS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    localparam logic [WIDTH-1:0] LAST = WIDTH'(ITERATIONS - 1);

    assign tc_o  = (cnt_q == LAST);
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || (en_i && tc_o)) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/cordic_sequencer.sv
// Steps the CORDIC datapath: LOAD, optional PRE, ITERATIONS micro-rotations, LATCH, DONE pulse.
// Optional quadrant pre-rotation is compiled in with macro CORDIC_QUAD_CORR_EN.
module cordic_sequencer
    import cordic_pkg::*;
#(
    parameter int ITERATION_WIDTH = CORDIC_ITERATION_WIDTH,
    parameter int ITERATIONS      = CORDIC_ITERATIONS
) (
    input  logic               clk,
    input  logic               rst,
    cordic_sequencer_if.slave  sif
);
    cordic_state_e              state_q;
    cordic_state_e              state_d;
    logic                       busy_q;
    logic                       load_q;
    logic                       pre_rot_q;
    logic                       iter_en_q;
    logic                       out_latch_q;
    logic                       done_q;
    logic [ITERATION_WIDTH-1:0] cnt;
    logic                       cnt_tc;

    cordic_iter_counter #(
        .WIDTH      (ITERATION_WIDTH),
        .ITERATIONS (ITERATIONS)
    ) u_iter_counter (
        .clk   (clk),
        .rst   (rst),
        .clr_i (sif.abort || (state_q != ST_ITER)),
        .en_i  (state_q == ST_ITER),
        .cnt_o (cnt),
        .tc_o  (cnt_tc)
    );

`ifndef CORDIC_QUAD_CORR_EN
    logic unused_x_neg;
    assign unused_x_neg = sif.x_neg;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (sif.start) state_d = ST_LOAD;
`ifdef CORDIC_QUAD_CORR_EN
            ST_LOAD:  state_d = sif.x_neg ? ST_PRE : ST_ITER;
            ST_PRE:   state_d = ST_ITER;
`else
            ST_LOAD:  state_d = ST_ITER;
`endif
            ST_ITER:  if (cnt_tc) state_d = ST_LATCH;
            ST_LATCH: state_d = ST_DONE;
            ST_DONE:  state_d = sif.start ? ST_LOAD : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // Abort outranks everything, including a start seen in IDLE or DONE.
        if (sif.abort) state_d = ST_IDLE;
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            load_q      <= 1'b0;
            pre_rot_q   <= 1'b0;
            iter_en_q   <= 1'b0;
            out_latch_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != ST_IDLE);
            load_q      <= (state_d == ST_LOAD);
            pre_rot_q   <= (state_d == ST_PRE);
            iter_en_q   <= (state_d == ST_ITER);
            out_latch_q <= (state_d == ST_LATCH);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign sif.busy      = busy_q;
    assign sif.load      = load_q;
`ifdef CORDIC_QUAD_CORR_EN
    assign sif.pre_rot   = pre_rot_q;
`else
    logic unused_pre_rot;
    assign unused_pre_rot = pre_rot_q;
    assign sif.pre_rot   = 1'b0;
`endif
    assign sif.iter_en   = iter_en_q;
    assign sif.iter_idx  = iter_en_q ? cnt : '0;
    assign sif.out_latch = out_latch_q;
    assign sif.done      = done_q;
endmodule

// File: doc/cordic_sequencer.md
# cordic_sequencer

Iterative sequencer for the CORDIC vectoring datapath. It accepts a start request, loads the operands, and steps the datapath through a fixed number of micro-rotations, issuing the iteration index on each one. It then latches the phase result and reports completion. It replaces the free-running control unit next to `cordic` inside `interface`, and drives every datapath enable explicitly.

## Interface
Parameters:
- `ITERATION_WIDTH`, 4, width of the iteration index; must satisfy `ITERATIONS <= 2**ITERATION_WIDTH`.
- `ITERATIONS`, 16, number of micro-rotations per operation (≥1).

Ports:
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst`  input  1  reset; asynchronous, active-low.
- `start`  input  1  request a new operation; sampled only in IDLE or DONE.
- `abort`  input  1  synchronous cancel; highest priority after reset.
- `x_neg`  input  1  sign of `x_in`, sampled in LOAD; used only when `CORDIC_QUAD_CORR_EN` is defined.
- `busy`  output  1  high in every state except IDLE.
- `load`  output  1  datapath loads `x_in`/`y_in`, clears z.
- `pre_rot`  output  1  datapath applies ±90° quadrant pre-rotation.
- `iter_en`  output  1  datapath performs one micro-rotation.
- `iter_idx`  output  `ITERATION_WIDTH`  shift amount / arctan-table index.
- `out_latch`  output  1  datapath captures `z_out`.
- `done`  output  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, PRE (only with macro), ITER, LATCH, DONE.
- All outputs are a Moore decode of registered state and counter, with no combinational path from inputs to outputs.
- IDLE:
  - `start`=1 → LOAD.
  - otherwise stay.
- LOAD (`load`=1):
  - → PRE if the macro is defined and `x_neg`=1.
  - → ITER otherwise.
- PRE (`pre_rot`=1) → ITER.
- ITER (`iter_en`=1):
  - `iter_idx` = counter, counting 0 … `ITERATIONS`-1.
  - at `ITERATIONS`-1 → LATCH.
  - The counter never wraps.
- LATCH (`out_latch`=1) → DONE.
- DONE (`done`=1):
  - `start`=1 → LOAD (back-to-back operation).
  - otherwise → IDLE.
- `start` in LOAD, PRE, ITER or LATCH is ignored, not queued.
- `abort`=1 in any state → IDLE next edge, counter cleared, no `done`.
  - Abort beats a simultaneous `start`.
  - Abort in DONE still leaves the completed result latched.
- `iter_idx` is 0 outside ITER.

## Timing
- Reset (`rst`=0), asynchronously:
  - state=IDLE, counter=0.
  - `busy`, `load`, `pre_rot`, `iter_en`, `out_latch`, `done` = 0; `iter_idx`=0.
- Reset mid-operation aborts immediately; no `done` follows.
- `start` high at edge k:
  - LOAD during cycle k+1.
  - ITER during cycles k+2 … k+ITERATIONS+1.
  - LATCH at k+ITERATIONS+2.
  - `done` at k+ITERATIONS+3.
  - Start-to-done latency is `ITERATIONS`+3 cycles; add 1 when PRE is taken.
- `busy` rises the cycle after `start` is accepted. It falls the cycle after DONE, unless a back-to-back start is accepted in DONE.
- Back-to-back throughput: one result every `ITERATIONS`+3 (or +4) cycles.

## Configuration
- `CORDIC_QUAD_CORR_EN` defined:
  - PRE state exists.
  - `x_neg` sampled in LOAD selects PRE; `pre_rot` pulses once.
  - This extends convergence to all four quadrants.
- `CORDIC_QUAD_CORR_EN` undefined:
  - no PRE state; `pre_rot` tied 0; `x_neg` ignored.
  - latency is always `ITERATIONS`+3.

## Structure
- Shared package `cordic_pkg`:
  - state enumeration.
  - default `ITERATIONS`/`ITERATION_WIDTH` constants, mirroring `settings.h`.
  - a latency constant.
- Sub-module `cordic_iter_counter`: clear/enable counter with a terminal-count flag at `ITERATIONS`-1, instantiated once.
- The state register and output decode live in `cordic_sequencer`.

## Test plan
All scenarios use `ITERATIONS`=16, `ITERATION_WIDTH`=4.
- Single op:
  - stimulus: `start` pulse at edge 0, macro off.
  - required: `load` in cycle 1; `iter_en` in cycles 2–17 with `iter_idx` 0…15; `out_latch` in cycle 18; `done` in cycle 19; `busy` low in cycle 20.
- Quadrant correction:
  - stimulus: macro on, `x_neg`=1.
  - required: `pre_rot` in cycle 2; `iter_idx` 0…15 in cycles 3–18; `done` in cycle 20.
  - with `x_neg`=0, `done` is in cycle 19.
- Back-to-back:
  - stimulus: `start` held high continuously.
  - required: `done` in cycles 19, 38, 57; `busy` never drops.
- Ignored start:
  - stimulus: extra `start` pulses during ITER.
  - required: exactly one `done`, in cycle 19.
- Abort:
  - stimulus: `abort` at `iter_idx`=7, with `start` asserted in the same cycle.
  - required: IDLE next cycle, all outputs 0, no `done`; a fresh `start` completes normally 19 cycles later.
- Async reset:
  - stimulus: `rst` low mid-LATCH, between clock edges.
  - required: all outputs go 0 immediately, no `done`; after release, `start` yields `done` 19 cycles later.
